jtcontra_romslot: RTL and testbench
===================================

# jtcontra_romslot

Single SDRAM read slot with a two-entry 32-bit line cache, sitting between one ROM consumer (main CPU, sound CPU, PCM or GFX fetcher) and the SDRAM request port of the ROM arbiter. It turns a chip-select plus byte/halfword address into a 32-bit SDRAM burst request at a fixed offset. Data is returned from cache with a registered `slot_ok`. Repeated accesses within a fetched 32-bit line cost no SDRAM traffic.

## Interface
Parameters:
- `AW`, 18, consumer address width (DW=8: byte address; DW=16: halfword address)
- `DW`, 8, consumer data width; legal values are 8 and 16 only
- `OFFSET`, 22'h0, slot base in SDRAM 16-bit word units; added modulo 2^22

Ports:
- `clk`  in  1  system clock; all logic on the rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `clr`  in  1  invalidate both cache entries (pulse after ROM download)
- `slot_cs`  in  1  consumer read request
- `slot_addr`  in  AW  consumer address
- `slot_dout`  out  DW  read data
- `slot_ok`  out  1  `slot_dout` is valid for the current `slot_addr`
- `sdram_req`  out  1  SDRAM read request, level
- `sdram_addr`  out  22  SDRAM word address of the 32-bit line
- `sdram_ack`  in  1  arbiter accepted the request
- `data_rdy`  in  1  `data_read` valid this cycle
- `data_read`  in  32  line data; `[15:0]` is the lower SDRAM word

## Operation
- **Line tag and line address**
  - DW=8: tag = `slot_addr[AW-1:2]`, lane = `slot_addr[1:0]`; line word address = `{tag,1'b0}`.
  - DW=16: tag = `slot_addr[AW-1:1]`, lane = `slot_addr[0]`; line word address = `{tag,1'b0}`.
  - `sdram_addr` = line word address zero-extended to 22 bits, + `OFFSET`, truncated to 22 bits.
- **Lane select**: `slot_dout` = `data >> (DW*lane)`, truncated to DW bits. Byte 0 (even address) is `data[7:0]`.
- **Cache**
  - Two entries, each holding {valid, tag, data[31:0]}.
  - Hit = `slot_cs` and a valid entry whose tag matches.
  - Fills go to the entry selected by a 1-bit pointer; the pointer toggles after every fill (round-robin).
- **FSM**
  - IDLE: if `slot_cs` and miss, latch `sdram_addr`, set `sdram_req`=1, go to WAIT_ACK. Otherwise stay.
  - WAIT_ACK: hold `sdram_req` and `sdram_addr` stable until `sdram_ack`=1. On ack, clear `sdram_req` and go to WAIT_RDY. `data_rdy` is ignored in this state.
  - WAIT_RDY: on `data_rdy`, write {1, latched tag, `data_read`} into the pointer entry, toggle the pointer, go to IDLE.
- **Mid-fetch changes**
  - An address change or `slot_cs` drop during WAIT_ACK/WAIT_RDY does not abort the fetch; the fill completes and acts as a prefetch.
  - IDLE then re-evaluates the current address.
- **Clear**
  - `clr`=1 clears both valid bits and the pointer.
  - If `clr` is seen while in WAIT_ACK/WAIT_RDY, a drop flag is set; the pending fill then returns to IDLE without writing valid.
  - If `clr` and `data_rdy` occur in the same cycle, `clr` wins and no fill happens.
- **Output registers**
  - Each cycle: `ok_r` ← hit; `addr_r` ← `slot_addr`; `slot_dout` ← hit-entry lane data (held when there is no hit).
  - `slot_ok` = `ok_r & slot_cs & (slot_addr == addr_r)`. The combinational qualifier ensures `slot_ok` never refers to a stale address.

## Timing
- **Reset** (`rst_n`=0 at an edge):
  - state IDLE, `sdram_req` 0, `sdram_addr` 0, `slot_dout` 0, `slot_ok` 0.
  - Valid bits 0, pointer 0, drop flag 0, `ok_r` 0, `addr_r` 0.
  - Reset during a fetch abandons the fetch; a later `data_rdy` is ignored in IDLE.
- **Hit latency**: `slot_cs` with a hitting address sampled at edge n → `slot_ok`=1 after edge n.
- **Miss latency**
  - Miss sampled at edge n → `sdram_req`=1 after edge n.
  - Ack sampled at edge a → `sdram_req`=0 after edge a.
  - `data_rdy` sampled at edge m → entry valid after m → `slot_ok`=1 after edge m+1.
- **Throughput**: at most one outstanding request; there is no new request until the FSM is back in IDLE.
- `sdram_req` never falls before `sdram_ack` unless `rst_n`=0.

## Test plan
- **Reset**: hold `rst_n`=0 with `slot_cs`=1 → all outputs 0, no `sdram_req`. Release → `sdram_req` the cycle after the first sampled miss.
- **Miss then hit** (DW=8, OFFSET=22'h1_0000)
  - Stimulus: read addr 0x00005; ack 3 cycles later; `data_rdy` with 32'hDDCCBBAA.
  - Required: `sdram_addr`=22'h1_0002; `slot_ok` one edge after `data_rdy` with `slot_dout`=8'hBB.
  - Then addr 0x00007 → 8'hDD with 1-cycle latency and no `sdram_req`.
- **Round-robin eviction**
  - Fill lines 0x0, 0x4, 0x8 in order.
  - Required: line 0x0 is evicted and re-requested; 0x8 still hits with no new request.
- **Clear mid-fetch**: `clr` during WAIT_RDY, then `data_rdy` → no `slot_ok`; a new `sdram_req` for the same line follows.
- **Simultaneous `clr` and `data_rdy`** → no fill, both valid bits 0.
- **DW=16 and offset wrap** (OFFSET=22'h3F_FFFE)
  - Stimulus: halfword addr 1; data 32'h5678_1234.
  - Required: `sdram_addr`=22'h3F_FFFE; `slot_dout`=16'h5678.
  - Then addr 0x2 → `sdram_addr`=22'h00_0000 (wrap).

Source files
------------

// File: rtl/jtcontra_romslot_if.sv
// Bus bundle for one ROM slot: the consumer read port plus the SDRAM request/data port.
// "master" is the environment (consumer and arbiter); "slave" is the slot itself.
interface jtcontra_romslot_if #(
    parameter int unsigned AW = 18,
    parameter int unsigned DW = 8
);
    logic          slot_cs;
    logic [AW-1:0] slot_addr;
    logic [DW-1:0] slot_dout;
    logic          slot_ok;
    logic          sdram_req;
    logic [21:0]   sdram_addr;
    logic          sdram_ack;
    logic          data_rdy;
    logic [31:0]   data_read;

    modport master (
        output slot_cs, slot_addr, sdram_ack, data_rdy, data_read,
        input  slot_dout, slot_ok, sdram_req, sdram_addr
    );

    modport slave (
        input  slot_cs, slot_addr, sdram_ack, data_rdy, data_read,
        output slot_dout, slot_ok, sdram_req, sdram_addr
    );
endinterface

// File: rtl/jtcontra_romslot.sv
// SDRAM read slot with a two-entry round-robin cache of 32-bit lines.
// DW must be 8 or 16; anything other than 16 is treated as byte lanes.
module jtcontra_romslot #(
    parameter int unsigned AW     = 18,
    parameter int unsigned DW     = 8,
    parameter logic [21:0] OFFSET = 22'h0
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    jtcontra_romslot_if.slave bus
);
    localparam int unsigned LW = (DW == 16) ? 1 : 2;
    localparam int unsigned TW = AW - LW;

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RDY} state_t;

    state_t        state;
    logic [1:0]    valid;
    logic [TW-1:0] tags  [2];
    logic [31:0]   lines [2];
    logic          ptr;
    logic          drop;
    logic [TW-1:0] fetch_tag;
    logic          req_r;
    logic [21:0]   saddr_r;

    logic          ok_r;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] dout_r;

    logic [TW-1:0] cur_tag;
    logic [LW-1:0] cur_lane;
    logic [1:0]    match;
    logic          hit;
    logic [31:0]   hit_line;
    logic [DW-1:0] lane_data;
    logic [21:0]   line_addr;

    always_comb begin
        cur_tag   = bus.slot_addr[AW-1:LW];
        cur_lane  = bus.slot_addr[LW-1:0];
        match[0]  = valid[0] && (tags[0] == cur_tag);
        match[1]  = valid[1] && (tags[1] == cur_tag);
        hit       = bus.slot_cs && (match != 2'b00);
        hit_line  = match[1] ? lines[1] : lines[0];
        lane_data = DW'(hit_line >> (32'(cur_lane) * DW));
        line_addr = 22'({cur_tag, 1'b0}) + OFFSET;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            valid     <= '0;
            ptr       <= 1'b0;
            drop      <= 1'b0;
            req_r     <= 1'b0;
            saddr_r   <= '0;
            fetch_tag <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.slot_cs && !hit) begin
                        saddr_r   <= line_addr;
                        fetch_tag <= cur_tag;
                        req_r     <= 1'b1;
                        drop      <= 1'b0;
                        state     <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (bus.sdram_ack) begin
                        req_r <= 1'b0;
                        state <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (bus.data_rdy) begin
                        // A clear seen at any point of the fetch discards the returning line
                        if (!drop && !clr) begin
                            valid[ptr] <= 1'b1;
                            tags[ptr]  <= fetch_tag;
                            lines[ptr] <= bus.data_read;
                            ptr        <= ~ptr;
                        end
                        state <= IDLE;
                    end
                end
                default: begin
                    req_r <= 1'b0;
                    state <= IDLE;
                end
            endcase
            if (clr) begin
                valid <= '0;
                ptr   <= 1'b0;
                if (state != IDLE) drop <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ok_r   <= 1'b0;
            addr_r <= '0;
            dout_r <= '0;
        end else begin
            ok_r   <= hit;
            addr_r <= bus.slot_addr;
            if (hit) dout_r <= lane_data;
        end
    end

    // The address compare keeps slot_ok from vouching for data fetched for a previous address
    assign bus.slot_ok    = ok_r && bus.slot_cs && (bus.slot_addr == addr_r);
    assign bus.slot_dout  = dout_r;
    assign bus.sdram_req  = req_r;
    assign bus.sdram_addr = saddr_r;
endmodule

// File: tb/tb_jtcontra_romslot.sv
// Two slots (byte lanes with a mid offset, halfword lanes with a wrapping offset) checked
// every cycle against a line-cache model, with directed scenarios and random traffic.
module tb_jtcontra_romslot;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        cs    [2];
    logic [17:0] addr  [2];
    logic        clr_i [2];
    logic        ack   [2];
    logic        rdy   [2];
    logic [31:0] rd    [2];

    jtcontra_romslot_if #(.AW(18), .DW(8))  ia();
    jtcontra_romslot_if #(.AW(18), .DW(16)) ib();

    assign ia.slot_cs   = cs[0];
    assign ia.slot_addr = addr[0];
    assign ia.sdram_ack = ack[0];
    assign ia.data_rdy  = rdy[0];
    assign ia.data_read = rd[0];
    assign ib.slot_cs   = cs[1];
    assign ib.slot_addr = addr[1];
    assign ib.sdram_ack = ack[1];
    assign ib.data_rdy  = rdy[1];
    assign ib.data_read = rd[1];

    jtcontra_romslot #(.AW(18), .DW(8), .OFFSET(22'h1_0000)) u_a (
        .clk(clk), .rst_n(rst_n), .clr(clr_i[0]), .bus(ia)
    );
    jtcontra_romslot #(.AW(18), .DW(16), .OFFSET(22'h3F_FFFE)) u_b (
        .clk(clk), .rst_n(rst_n), .clr(clr_i[1]), .bus(ib)
    );

    int checks = 0;
    int errors = 0;

    // Model: cache contents plus a description of the outstanding fetch
    bit          m_valid [2][2];
    int unsigned m_tag   [2][2];
    logic [31:0] m_data  [2][2];
    bit          m_ptr   [2];
    bit          busy    [2];
    bit          mreq    [2];
    bit          drop    [2];
    int unsigned ftag    [2];
    logic [21:0] saddr   [2];
    bit          ok_r    [2];
    logic [17:0] addr_r  [2];
    logic [15:0] dout    [2];

    logic        g_ok    [2];
    logic [15:0] g_dout  [2];
    logic        g_req   [2];
    logic [21:0] g_saddr [2];

    function automatic int unsigned tag_of(input int k, input logic [17:0] a);
        return (k == 1) ? int'(a) / 2 : int'(a) / 4;
    endfunction

    function automatic int unsigned lane_of(input int k, input logic [17:0] a);
        return (k == 1) ? int'(a) % 2 : int'(a) % 4;
    endfunction

    function automatic logic [21:0] word_of(input int k, input int unsigned t);
        longint unsigned off;
        off = (k == 1) ? 64'h3F_FFFE : 64'h1_0000;
        return 22'((longint'(t) * 2 + off) % 64'h40_0000);
    endfunction

    function automatic logic [15:0] pick(input int k, input logic [31:0] d, input int unsigned ln);
        int unsigned w;
        w = (k == 1) ? 16 : 8;
        return 16'((d >> (w * ln)) & ((32'h1 << w) - 1));
    endfunction

    task automatic model_edge(input int k);
        int unsigned t;
        int hi;
        bit found;
        bit hit;
        bit was_busy;
        if (!rst_n) begin
            for (int e = 0; e < 2; e++) m_valid[k][e] = 0;
            m_ptr[k] = 0; busy[k] = 0; mreq[k] = 0; drop[k] = 0;
            saddr[k] = '0; ok_r[k] = 0; addr_r[k] = '0; dout[k] = '0;
            return;
        end
        t = tag_of(k, addr[k]);
        found = 0; hi = 0;
        for (int e = 0; e < 2; e++)
            if (m_valid[k][e] && m_tag[k][e] == t) begin found = 1; hi = e; end
        hit = cs[k] && found;
        ok_r[k] = hit;
        addr_r[k] = addr[k];
        if (hit) dout[k] = pick(k, m_data[k][hi], lane_of(k, addr[k]));
        was_busy = busy[k];
        if (busy[k] && !mreq[k]) begin
            if (rdy[k]) begin
                if (!clr_i[k] && !drop[k]) begin
                    m_valid[k][m_ptr[k]] = 1;
                    m_tag[k][m_ptr[k]]   = ftag[k];
                    m_data[k][m_ptr[k]]  = rd[k];
                    m_ptr[k] = !m_ptr[k];
                end
                busy[k] = 0;
            end
        end else if (mreq[k]) begin
            if (ack[k]) mreq[k] = 0;
        end else if (cs[k] && !hit) begin
            busy[k] = 1; mreq[k] = 1; drop[k] = 0;
            ftag[k] = t;
            saddr[k] = word_of(k, t);
        end
        if (clr_i[k]) begin
            for (int e = 0; e < 2; e++) m_valid[k][e] = 0;
            m_ptr[k] = 0;
            if (was_busy) drop[k] = 1;
        end
    endtask

    task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s slot%0d t=%0t got %h expected %h", name, k, $time, got, exp);
        end
    endtask

    task automatic compare(input int k);
        bit exp_ok;
        if (k == 0) begin
            g_ok[0] = ia.slot_ok; g_dout[0] = {8'h00, ia.slot_dout};
            g_req[0] = ia.sdram_req; g_saddr[0] = ia.sdram_addr;
        end else begin
            g_ok[1] = ib.slot_ok; g_dout[1] = ib.slot_dout;
            g_req[1] = ib.sdram_req; g_saddr[1] = ib.sdram_addr;
        end
        exp_ok = ok_r[k] && cs[k] && (addr[k] == addr_r[k]);
        chk("slot_ok", k, 32'(g_ok[k]), 32'(exp_ok));
        chk("slot_dout", k, 32'(g_dout[k]), 32'(dout[k]));
        chk("sdram_req", k, 32'(g_req[k]), 32'(mreq[k]));
        chk("sdram_addr", k, 32'(g_saddr[k]), 32'(saddr[k]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        @(negedge clk);
        compare(0);
        compare(1);
    endtask

    task automatic quiet(input int k);
        cs[k] = 0; clr_i[k] = 0; ack[k] = 0; rdy[k] = 0;
    endtask

    task automatic fetch(input int k, input logic [17:0] a, input logic [31:0] d);
        cs[k] = 1; addr[k] = a; ack[k] = 0; rdy[k] = 0;
        step();
        chk("fetch_req", k, 32'(g_req[k]), 32'd1);
        ack[k] = 1; step();
        ack[k] = 0; rdy[k] = 1; rd[k] = d; step();
        rdy[k] = 0; step();
        chk("fetch_ok", k, 32'(g_ok[k]), 32'd1);
    endtask

    initial begin
        rst_n = 0;
        for (int k = 0; k < 2; k++) begin
            quiet(k); cs[k] = 1; addr[k] = '0; rd[k] = '0;
            busy[k] = 0; mreq[k] = 0; m_ptr[k] = 0; drop[k] = 0;
            saddr[k] = '0; ok_r[k] = 0; addr_r[k] = '0; dout[k] = '0;
            for (int e = 0; e < 2; e++) begin m_valid[k][e] = 0; m_tag[k][e] = 0; m_data[k][e] = '0; end
        end
        repeat (3) step();
        for (int k = 0; k < 2; k++) begin
            chk("rst_req", k, 32'(g_req[k]), 32'd0);
            chk("rst_ok", k, 32'(g_ok[k]), 32'd0);
            chk("rst_dout", k, 32'(g_dout[k]), 32'd0);
            chk("rst_saddr", k, 32'(g_saddr[k]), 32'd0);
        end

        // Miss then hit on the byte slot
        rst_n = 1; quiet(1); addr[0] = 18'h5;
        step();
        chk("miss_req", 0, 32'(g_req[0]), 32'd1);
        chk("miss_saddr", 0, 32'(g_saddr[0]), 32'h1_0002);
        step(); step();
        chk("req_held", 0, 32'(g_req[0]), 32'd1);
        ack[0] = 1; step();
        chk("ack_drop", 0, 32'(g_req[0]), 32'd0);
        ack[0] = 0; step();
        rdy[0] = 1; rd[0] = 32'hDDCC_BBAA; step();
        chk("fill_ok_early", 0, 32'(g_ok[0]), 32'd0);
        rdy[0] = 0; step();
        chk("fill_ok", 0, 32'(g_ok[0]), 32'd1);
        chk("fill_dout", 0, 32'(g_dout[0]), 32'hBB);
        addr[0] = 18'h7; step();
        chk("hit_ok", 0, 32'(g_ok[0]), 32'd1);
        chk("hit_dout", 0, 32'(g_dout[0]), 32'hDD);
        chk("hit_noreq", 0, 32'(g_req[0]), 32'd0);

        // Round-robin eviction
        cs[0] = 0; clr_i[0] = 1; step(); clr_i[0] = 0;
        fetch(0, 18'h0, 32'h0302_0100);
        fetch(0, 18'h4, 32'h1312_1110);
        fetch(0, 18'h8, 32'h2322_2120);
        addr[0] = 18'h9; step();
        chk("rr_hit8_ok", 0, 32'(g_ok[0]), 32'd1);
        chk("rr_hit8_dout", 0, 32'(g_dout[0]), 32'h21);
        chk("rr_hit8_noreq", 0, 32'(g_req[0]), 32'd0);
        addr[0] = 18'h0; step();
        chk("rr_evict_req", 0, 32'(g_req[0]), 32'd1);
        chk("rr_evict_saddr", 0, 32'(g_saddr[0]), 32'h1_0000);
        ack[0] = 1; step(); ack[0] = 0; rdy[0] = 1; rd[0] = 32'h0302_0100; step(); rdy[0] = 0; step();

        // Clear while waiting for data
        addr[0] = 18'h10; step();
        chk("clr_saddr", 0, 32'(g_saddr[0]), 32'h1_0008);
        ack[0] = 1; step();
        ack[0] = 0; clr_i[0] = 1; step();
        clr_i[0] = 0; rdy[0] = 1; rd[0] = 32'hCAFE_F00D; step();
        rdy[0] = 0; step();
        chk("clr_no_ok", 0, 32'(g_ok[0]), 32'd0);
        chk("clr_rereq", 0, 32'(g_req[0]), 32'd1);
        chk("clr_rereq_addr", 0, 32'(g_saddr[0]), 32'h1_0008);
        ack[0] = 1; step(); ack[0] = 0; rdy[0] = 1; rd[0] = 32'h4443_4241; step(); rdy[0] = 0; step();
        chk("clr_refill_dout", 0, 32'(g_dout[0]), 32'h41);

        // Clear and data in the same cycle
        addr[0] = 18'h20; step();
        ack[0] = 1; step();
        ack[0] = 0; clr_i[0] = 1; rdy[0] = 1; step();
        clr_i[0] = 0; rdy[0] = 0; cs[0] = 0; step();
        cs[0] = 1; step();
        chk("clrrdy_req", 0, 32'(g_req[0]), 32'd1);
        chk("clrrdy_ok", 0, 32'(g_ok[0]), 32'd0);
        ack[0] = 1; step(); ack[0] = 0; rdy[0] = 1; step(); rdy[0] = 0; step();
        quiet(0);

        // Halfword slot with wrapping offset
        cs[1] = 1; addr[1] = 18'h1; step();
        chk("hw_saddr", 1, 32'(g_saddr[1]), 32'h3F_FFFE);
        ack[1] = 1; step();
        ack[1] = 0; rdy[1] = 1; rd[1] = 32'h5678_1234; step();
        rdy[1] = 0; step();
        chk("hw_ok", 1, 32'(g_ok[1]), 32'd1);
        chk("hw_dout", 1, 32'(g_dout[1]), 32'h5678);
        addr[1] = 18'h2; step();
        chk("hw_wrap_req", 1, 32'(g_req[1]), 32'd1);
        chk("hw_wrap_saddr", 1, 32'(g_saddr[1]), 32'h0);
        ack[1] = 1; step(); ack[1] = 0; rdy[1] = 1; rd[1] = 32'h9ABC_DEF0; step(); rdy[1] = 0; step();

        // Random traffic on both slots
        for (int n = 0; n < 4000; n++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            for (int k = 0; k < 2; k++) begin
                cs[k] = ($urandom_range(0, 9) < 8);
                if ($urandom_range(0, 9) < 3)
                    addr[k] = 18'($urandom_range(0, (k == 1) ? 11 : 23));
                clr_i[k] = ($urandom_range(0, 39) == 0);
                ack[k] = ($urandom_range(0, 2) == 0);
                rdy[k] = ($urandom_range(0, 2) == 0);
                rd[k] = $urandom;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
